// File: rtl/position_decoder.sv
// Purpose : tic-tac-toe cell-select decoder. Turns a board position (0..8, row-major)
//           into a registered one-hot cell write-enable and flags out-of-range codes.
// Latency : 1 clk, with no combinational path from inputs to outputs.
// Backpr. : none. The block decodes every cycle, and the outputs never hold past one edge.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous, active-high reset; clears out_en and invalid immediately
//   in      - board position, valid codes 0..8
//   enable  - decode request; when low no cell is selected and in is ignored
//   out_en  - one-hot cell write-enable, bit k selects cell k (all zero when idle)
//   invalid - enable was high with in > 8 at the previous edge
module position_decoder #(
  parameter int NUM_CELLS = 9,  // 3x3 board; the decode table below assumes exactly 9
  parameter int POS_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [POS_W-1:0]     in,
  input  logic                 enable,
  output logic [NUM_CELLS-1:0] out_en,
  output logic                 invalid
);

  logic [NUM_CELLS-1:0] out_en_d;
  logic [NUM_CELLS-1:0] out_en_q;
  logic                 invalid_d;
  logic                 invalid_q;

  // The enable gate sits outside the case. An X/Z on in while idle therefore never
  // reaches the flops. The full case with a zero default keeps the result one-hot or empty.
  always_comb begin
    out_en_d  = '0;
    invalid_d = 1'b0;
    if (enable) begin
      case (in)
        4'd0:    out_en_d = 9'b000000001;
        4'd1:    out_en_d = 9'b000000010;
        4'd2:    out_en_d = 9'b000000100;
        4'd3:    out_en_d = 9'b000001000;
        4'd4:    out_en_d = 9'b000010000;
        4'd5:    out_en_d = 9'b000100000;
        4'd6:    out_en_d = 9'b001000000;
        4'd7:    out_en_d = 9'b010000000;
        4'd8:    out_en_d = 9'b100000000;
        default: begin
          // Codes 9..15 have no cell. No cell is written, and the bad request is reported.
          out_en_d  = '0;
          invalid_d = 1'b1;
        end
      endcase
    end
  end

  // The flops reload on every edge, so nothing is held or replayed across a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en_q  <= '0;
      invalid_q <= 1'b0;
    end else begin
      out_en_q  <= out_en_d;
      invalid_q <= invalid_d;
    end
  end

  assign out_en  = out_en_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_position_decoder.sv
// Purpose : directed bench for position_decoder with hand-computed expectations.
// Latency : the bench applies inputs 1 ns after a rising edge and checks 1 ns after the following edge.
// Backpr. : not applicable.
module tb_position_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic       enable;
  logic [8:0] out_en;
  logic       invalid;

  int total;
  int bad;

  position_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .enable  (enable),
    .out_en  (out_en),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp_oh;
    total  = 0;
    bad    = 0;

    // 1. Reset clears the outputs with no clock edge, and holding reset through edges keeps them clear.
    rst    = 1'b1;
    in     = 4'd4;
    enable = 1'b1;
    #2;
    chk("rst_noedge_out", 16'(out_en), 16'h0);
    chk("rst_noedge_inv", 16'(invalid), 16'h0);
    step();
    step();
    chk("rst_held_out", 16'(out_en), 16'h0);
    chk("rst_held_inv", 16'(invalid), 16'h0);
    rst = 1'b0;

    // 2. Disabled sweep: nothing is selected.
    enable = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in = 4'(k);
      step();
      chk($sformatf("dis_out_%0d", k), 16'(out_en), 16'h0);
      chk($sformatf("dis_inv_%0d", k), 16'(invalid), 16'h0);
    end

    // X on in while disabled must not leak to the outputs.
    in = 4'bxxxx;
    step();
    chk("dis_x_out", 16'(out_en), 16'h0);
    chk("dis_x_inv", 16'(invalid), 16'h0);

    // 3. Enabled sweep: each position selects its own cell.
    enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in = 4'(k);
      exp_oh = 9'd1 << k;
      step();
      chk($sformatf("en_out_%0d", k), 16'(out_en), 16'(exp_oh));
      chk($sformatf("en_inv_%0d", k), 16'(invalid), 16'h0);
      chk($sformatf("en_onehot_%0d", k), 16'($countones(out_en)), 16'd1);
    end

    // 4. Out-of-range codes, then recovery to a valid code.
    in = 4'd9;
    step();
    chk("oor9_out", 16'(out_en), 16'h0);
    chk("oor9_inv", 16'(invalid), 16'h1);
    in = 4'd15;
    step();
    chk("oor15_out", 16'(out_en), 16'h0);
    chk("oor15_inv", 16'(invalid), 16'h1);
    in = 4'd3;
    step();
    chk("rec3_out", 16'(out_en), 16'h008);
    chk("rec3_inv", 16'(invalid), 16'h0);

    // 5. Toggle enable with in fixed at 8.
    in     = 4'd8;
    enable = 1'b1;
    step();
    chk("tog_on1", 16'(out_en), 16'h100);
    enable = 1'b0;
    step();
    chk("tog_off", 16'(out_en), 16'h000);
    enable = 1'b1;
    step();
    chk("tog_on2", 16'(out_en), 16'h100);

    // 6. Async reset mid-run. Reset clears the outputs between edges, and the request resumes only after a fresh edge.
    in = 4'd5;
    step();
    chk("ar_pre", 16'(out_en), 16'h020);
    step();
    chk("ar_hold", 16'(out_en), 16'h020);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_async_out", 16'(out_en), 16'h0);
    chk("ar_async_inv", 16'(invalid), 16'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_released_noedge", 16'(out_en), 16'h0);
    step();
    chk("ar_after_edge", 16'(out_en), 16'h020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
